// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Conditions the raw active-low KEY pins before they reach the
// oneshot / delay_ctrl / blinker chain. Each key passes through a two-flop
// synchronizer and then a stability counter. A change on the synchronized key
// is accepted only after it has held for DEBOUNCE_CYCLES consecutive cycles.
// The block produces a clean active-high pressed level and one-cycle
// press/release strobes for every key.
//
// Optional feature macro: KEY_DEBOUNCE_AUTOREPEAT_EN
//   When this macro is defined, a held key emits extra key_press strobes. The
//   first extra strobe comes REPEAT_DELAY cycles after the accepted press, and
//   later ones come every REPEAT_PERIOD cycles. When the macro is undefined,
//   no repeat logic is built and the REPEAT_* and RPT_WIDTH parameters are
//   ignored.
//
// Ports
//   clk          in   1      system clock (CLOCK_50 domain)
//   reset_n      in   1      synchronous reset, active low
//   key_raw      in   NKEYS  asynchronous raw keys, 0 = pressed
//   key_level    out  NKEYS  debounced state, 1 = pressed
//   key_press    out  NKEYS  1-cycle strobe on accepted press (and auto-repeat)
//   key_release  out  NKEYS  1-cycle strobe on accepted release
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int RPT_WIDTH       = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [RPT_WIDTH-1:0] RPT_DELAY_LAST  = RPT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [RPT_WIDTH-1:0] RPT_PERIOD_LAST = RPT_WIDTH'(REPEAT_PERIOD - 1);
`endif

    // Two-flop synchronizer. Both flops reset to 1, which is the released
    // level of the active-low pins.
    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] sync2_q;
    logic [NKEYS-1:0] key_s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would chain sync1 straight into sync2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = ~sync2_q;

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_state_t           state_q, state_nx;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_nx;
        logic                 press_q, press_nx;
        logic                 release_q, release_nx;
        logic                 level;
        logic                 differs;
        logic                 accept;

        assign level   = (state_q == PRESSED);
        assign differs = (key_s[k] != level);
        assign accept  = differs && (cnt_q == CNT_LAST);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        // rpt_armed_q is clear while the initial REPEAT_DELAY is being timed.
        // After the first repeat strobe it is set, and REPEAT_PERIOD is timed.
        logic [RPT_WIDTH-1:0] rpt_q, rpt_nx;
        logic                 rpt_armed_q, rpt_armed_nx;
        logic                 rpt_hit;

        assign rpt_hit = rpt_armed_q ? (rpt_q == RPT_PERIOD_LAST)
                                     : (rpt_q == RPT_DELAY_LAST);
`endif

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q     <= RELEASED;
                cnt_q       <= '0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                rpt_q       <= '0;
                rpt_armed_q <= 1'b0;
`endif
            end else begin
                state_q     <= state_nx;
                cnt_q       <= cnt_nx;
                press_q     <= press_nx;
                release_q   <= release_nx;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                rpt_q       <= rpt_nx;
                rpt_armed_q <= rpt_armed_nx;
`endif
            end
        end

        // NOTE: every signal this block drives gets a default first, so no
        // path leaves a value unassigned and no latch is inferred.
        always_comb begin
            state_nx   = state_q;
            cnt_nx     = '0;
            press_nx   = 1'b0;
            release_nx = 1'b0;

            // The counter restarts whenever the synchronized key agrees with
            // the accepted level. A single agreeing sample rejects a glitch.
            if (differs) begin
                if (accept) begin
                    state_nx   = key_s[k] ? PRESSED : RELEASED;
                    press_nx   = key_s[k];
                    release_nx = ~key_s[k];
                end else begin
                    cnt_nx = cnt_q + CNT_WIDTH'(1);
                end
            end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rpt_nx       = '0;
            rpt_armed_nx = 1'b0;
            // The repeat timer runs only while the key is held. A release
            // accepted in this cycle takes priority over a coincident repeat.
            if ((state_q == PRESSED) && !accept) begin
                if (rpt_hit) begin
                    press_nx     = 1'b1;
                    rpt_nx       = '0;
                    rpt_armed_nx = 1'b1;
                end else begin
                    rpt_nx       = rpt_q + RPT_WIDTH'(1);
                    rpt_armed_nx = rpt_armed_q;
                end
            end
`endif
        end

        assign key_level[k]   = level;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Directed bench for key_debounce. It uses NKEYS=4, DEBOUNCE_CYCLES=8,
// CNT_WIDTH=3, REPEAT_DELAY=20, REPEAT_PERIOD=6 and RPT_WIDTH=5.
//
// The stimulus process pushes every expected strobe into a queue. Each entry
// holds the clock-edge index at which the strobe should appear and the
// press/release vectors expected then. A separate monitor samples on the
// falling edge. When any strobe is present, it pops one entry and compares
// it. A queue entry whose cycle has already passed counts as a missed strobe.
// Edge n is the n-th rising edge. cyc equals n from just after that edge.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int NKEYS           = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int CNT_WIDTH       = 3;
    localparam int REPEAT_DELAY    = 20;
    localparam int REPEAT_PERIOD   = 6;
    localparam int RPT_WIDTH       = 5;
    localparam int LAT             = DEBOUNCE_CYCLES + 2;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [NKEYS-1:0] key_raw = '1;
    logic [NKEYS-1:0] key_level;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;

    key_debounce #(
        .NKEYS          (NKEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .RPT_WIDTH      (RPT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [NKEYS-1:0] press;
        logic [NKEYS-1:0] rel;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int c, input logic [NKEYS-1:0] p, input logic [NKEYS-1:0] r);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    // Advance past the next rising edge. Inputs are driven and outputs are
    // sampled 1 ns later.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_strobe_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if ((key_press | key_release) != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {key_press, key_release}, '0);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_press", key_press, e.press);
                check("strobe_release", key_release, e.rel);
            end
        end
    end

    initial begin : stim
        int t, u, r, p;

        // 1. Reset held for 3 cycles with all keys released.
        reset_n = 1'b0;
        key_raw = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_level", key_level, '0);
            check("rst_press", key_press, '0);
            check("rst_release", key_release, '0);
        end
        reset_n = 1'b1;
        step(4);
        check("post_rst_level", key_level, '0);

        // 2. Clean press and release on key 0.
        t = cyc;
        key_raw[0] = 1'b0;
        expect_ev(t + LAT, 4'b0001, 4'b0000);
        step(LAT - 1);
        check("k0_level_before_accept", key_level, 4'b0000);
        step();
        check("k0_level_pressed", key_level, 4'b0001);
        step(2);
        u = cyc;
        key_raw[0] = 1'b1;
        expect_ev(u + LAT, 4'b0000, 4'b0001);
        step(LAT - 1);
        check("k0_level_before_release", key_level, 4'b0001);
        step(3);
        check("k0_level_released", key_level, 4'b0000);

        // 3. Key 1 glitch: low for 5 cycles, high for 1, then low for 20.
        // The auto-repeat slot would coincide with the release acceptance,
        // so no repeat is expected.
        t = cyc;
        key_raw[1] = 1'b0;
        step(5);
        key_raw[1] = 1'b1;
        step();
        key_raw[1] = 1'b0;
        expect_ev(t + 6 + LAT, 4'b0010, 4'b0000);
        step(LAT - 1);
        check("k1_level_after_glitch", key_level, 4'b0000);
        step(20 - (LAT - 1));
        key_raw[1] = 1'b1;
        expect_ev(t + 26 + LAT, 4'b0000, 4'b0010);
        step(LAT + 2);
        check("k1_level_released", key_level, 4'b0000);

        // 4. Keys 2 and 3 change together.
        t = cyc;
        key_raw[3:2] = 2'b00;
        expect_ev(t + LAT, 4'b1100, 4'b0000);
        step(LAT + 2);
        check("k23_level_pressed", key_level, 4'b1100);
        u = cyc;
        key_raw = '1;
        expect_ev(u + LAT, 4'b0000, 4'b1100);
        step(LAT + 2);
        check("k23_level_released", key_level, 4'b0000);

        // 5. Reset while key 0 is held. The level drops with no release
        // strobe, and the press is re-accepted after reset.
        t = cyc;
        key_raw[0] = 1'b0;
        expect_ev(t + LAT, 4'b0001, 4'b0000);
        step(LAT);
        check("k0_held_level", key_level, 4'b0001);
        step();
        reset_n = 1'b0;
        step();
        check("k0_level_in_reset", key_level, 4'b0000);
        check("k0_release_in_reset", key_release, 4'b0000);
        reset_n = 1'b1;
        r = cyc;
        expect_ev(r + LAT, 4'b0001, 4'b0000);
        step(LAT - 1);
        check("k0_level_before_repress", key_level, 4'b0000);
        step();
        check("k0_level_repressed", key_level, 4'b0001);
        step(2);
        u = cyc;
        key_raw[0] = 1'b1;
        expect_ev(u + LAT, 4'b0000, 4'b0001);
        step(LAT + 2);

        // 6. Key 1 held for 60 cycles after the press strobe at p.
        t = cyc;
        p = t + LAT;
        key_raw[1] = 1'b0;
        expect_ev(p, 4'b0010, 4'b0000);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        for (int k = 0; p + REPEAT_DELAY + k * REPEAT_PERIOD < p + 60 + LAT; k++)
            expect_ev(p + REPEAT_DELAY + k * REPEAT_PERIOD, 4'b0010, 4'b0000);
`endif
        expect_ev(p + 60 + LAT, 4'b0000, 4'b0010);
        step(LAT + 60);
        check("k1_hold_level", key_level, 4'b0010);
        key_raw[1] = 1'b1;
        step(LAT + 4);
        check("k1_hold_released", key_level, 4'b0000);

        step(5);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
